// File: rtl/axi_wr_slave.sv
// AXI4 write-channel slave: one AW, a counted burst of W beats, one B response, over word memory.
// Build option AXI_ALIGN_CHECK_EN: an unaligned awaddr answers SLVERR and suppresses all writes.
module axi_wr_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        awaddr,
    input  logic [3:0]               awlen,
    input  logic [1:0]               awburst,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic                     wlast,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        dataout
);

    localparam int BPB = DATA_W / 8;
    localparam int AW  = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] BPB_A   = ADDR_W'(BPB);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_awready, w_awready_nxt;
    logic              r_wready, w_wready_nxt;
    logic              r_bvalid, w_bvalid_nxt;
    logic [1:0]        r_bresp, w_bresp_nxt;
    logic [AW-1:0]     r_addr, w_addr_nxt;
    logic [3:0]        r_len, w_len_nxt;
    logic [3:0]        r_beat_cnt, w_beat_cnt_nxt;
    logic              r_fixed, w_fixed_nxt;
    logic [1:0]        r_err, w_err_nxt;
    logic              r_proto_err, w_proto_err_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dataout;

    logic [ADDR_W-1:0] w_word_full;
    logic [1:0]        w_aw_err;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_last_beat;
    logic              w_wlast_bad;
    logic              w_do_write;

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign dataout = r_dataout;

    // Address-phase decode; DECERR is applied last so it overrides an alignment error.
    always_comb begin
        w_word_full = awaddr / BPB_A;
        w_aw_err    = RESP_OKAY;
`ifdef AXI_ALIGN_CHECK_EN
        if ((awaddr % BPB_A) != '0) begin
            w_aw_err = RESP_SLVERR;
        end
`endif
        if (w_word_full >= DEPTH_A) begin
            w_aw_err = RESP_DECERR;
        end
    end

    assign w_aw_hs     = (r_state == S_IDLE) && awvalid && r_awready;
    assign w_w_hs      = (r_state == S_DATA) && wvalid && r_wready;
    assign w_last_beat = (r_beat_cnt == r_len);
    // The beat counter decides where the burst ends; wlast is only cross-checked.
    assign w_wlast_bad = w_w_hs && (wlast != w_last_beat);
    assign w_do_write  = w_w_hs && (r_err == RESP_OKAY);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
        w_state_nxt     = r_state;
        w_awready_nxt   = r_awready;
        w_wready_nxt    = r_wready;
        w_bvalid_nxt    = r_bvalid;
        w_bresp_nxt     = r_bresp;
        w_addr_nxt      = r_addr;
        w_len_nxt       = r_len;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_fixed_nxt     = r_fixed;
        w_err_nxt       = r_err;
        w_proto_err_nxt = r_proto_err;

        case (r_state)
            S_IDLE: begin
                w_awready_nxt = 1'b1;
                if (w_aw_hs) begin
                    w_awready_nxt   = 1'b0;
                    w_wready_nxt    = 1'b1;
                    w_addr_nxt      = w_word_full[AW-1:0];
                    w_len_nxt       = awlen;
                    w_fixed_nxt     = (awburst == 2'b00);
                    w_beat_cnt_nxt  = 4'd0;
                    w_err_nxt       = w_aw_err;
                    w_proto_err_nxt = 1'b0;
                    w_state_nxt     = S_DATA;
                end
            end

            S_DATA: begin
                if (w_w_hs) begin
                    if (!r_fixed) begin
                        w_addr_nxt = r_addr + AW'(1);
                    end
                    w_beat_cnt_nxt  = r_beat_cnt + 4'd1;
                    w_proto_err_nxt = r_proto_err | w_wlast_bad;
                    if (w_last_beat) begin
                        w_wready_nxt = 1'b0;
                        w_bvalid_nxt = 1'b1;
                        w_state_nxt  = S_RESP;
                        if (r_err == RESP_DECERR) begin
                            w_bresp_nxt = RESP_DECERR;
                        end else if (r_err != RESP_OKAY || r_proto_err || w_wlast_bad) begin
                            w_bresp_nxt = RESP_SLVERR;
                        end else begin
                            w_bresp_nxt = RESP_OKAY;
                        end
                    end
                end
            end

            S_RESP: begin
                if (r_bvalid && bready) begin
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_addr      <= '0;
            r_len       <= 4'd0;
            r_beat_cnt  <= 4'd0;
            r_fixed     <= 1'b0;
            r_err       <= RESP_OKAY;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_awready   <= w_awready_nxt;
            r_wready    <= w_wready_nxt;
            r_bvalid    <= w_bvalid_nxt;
            r_bresp     <= w_bresp_nxt;
            r_addr      <= w_addr_nxt;
            r_len       <= w_len_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_fixed     <= w_fixed_nxt;
            r_err       <= w_err_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    // NOTE: the memory array has no reset so it maps onto RAM and keeps its contents across reset.
    always_ff @(posedge aclk) begin
        if (w_do_write) begin
            for (int b = 0; b < BPB; b++) begin
                if (wstrb[b]) begin
                    r_mem[r_addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Side-band read samples the pre-write word when it collides with a W beat.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_dataout <= '0;
        end else begin
            r_dataout <= r_mem[rd_addr];
        end
    end

endmodule
